// File: rtl/cmd_stream_arbiter_pkg.sv
// Shared helpers for the command stream arbiter: grant index width and the
// round-robin search used to pick the next source.
package cmd_stream_arbiter_pkg;

  localparam int GRANT_W     = 2;
  localparam int MAX_SOURCES = 4;

  // Search upward from last+1 (wrapping at num) for the first requester.
  // Returns last unchanged when nobody requests.
  function automatic logic [GRANT_W-1:0] rr_pick(
    input logic [MAX_SOURCES-1:0] req,
    input logic [GRANT_W-1:0]     last,
    input int                     num
  );
    logic [GRANT_W-1:0] pick;
    logic               found;
    int                 idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_SOURCES; i++) begin
      idx = (int'(last) + i) % num;
      if (!found && (i <= num) && req[idx[GRANT_W-1:0]]) begin
        pick  = idx[GRANT_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream register slice. The head entry drives the output
// directly from flops; the spare entry absorbs one beat when the consumer
// stalls, so the producer side sees a ready that depends only on occupancy.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [1:0] SKID_DEPTH = 2'd2;

  logic [1:0]            count_q;
  logic [DATA_WIDTH-1:0] head_data_q;
  logic [DATA_WIDTH-1:0] spare_data_q;
  logic                  head_last_q;
  logic                  spare_last_q;
  logic                  push;
  logic                  pop;

  assign s_ready = (count_q != SKID_DEPTH);
  assign m_valid = (count_q != 2'd0);
  assign m_data  = head_data_q;
  assign m_last  = head_last_q;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // Refill the head from the spare (or the input) whenever it is empty or
  // being consumed; otherwise park an incoming beat in the spare entry.
  always_ff @(posedge aclk) begin
    if (reset) begin
      count_q     <= 2'd0;
      head_last_q <= 1'b0;
    end else begin
      if ((count_q == 2'd0) || pop) begin
        if (count_q == SKID_DEPTH) begin
          head_data_q <= spare_data_q;
          head_last_q <= spare_last_q;
        end else if (push) begin
          head_data_q <= s_data;
          head_last_q <= s_last;
        end else begin
          head_last_q <= 1'b0;
        end
      end else if (push) begin
        spare_data_q <= s_data;
        spare_last_q <= s_last;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/cmd_stream_arbiter.sv
// Packet-level round-robin arbiter merging several command streams into one
// registered stream. A source keeps the grant until its tlast beat has been
// accepted; a one-cycle release follows before the next arbitration.
module cmd_stream_arbiter
  import cmd_stream_arbiter_pkg::*;
#(
  parameter int CMD_STREAM_WIDTH = 16,
  parameter int NUM_SOURCES      = 2
) (
  input  logic                                  aclk,
  input  logic                                  reset,
  input  logic [NUM_SOURCES-1:0]                s_cmd_axis_tvalid,
  output logic [NUM_SOURCES-1:0]                s_cmd_axis_tready,
  input  logic [NUM_SOURCES-1:0]                s_cmd_axis_tlast,
  input  logic [NUM_SOURCES*CMD_STREAM_WIDTH-1:0] s_cmd_axis_tdata,
  output logic                                  m_cmd_axis_tvalid,
  input  logic                                  m_cmd_axis_tready,
  output logic                                  m_cmd_axis_tlast,
  output logic [CMD_STREAM_WIDTH-1:0]           m_cmd_axis_tdata,
  output logic [1:0]                            dbgGrant,
  output logic                                  dbgLocked
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  arb_state_t            state_q;
  arb_state_t            state_d;
  logic [GRANT_W-1:0]    grant_q;
  logic [GRANT_W-1:0]    last_grant_q;
  logic [GRANT_W-1:0]    pick;
  logic                  release_q;
  logic [MAX_SOURCES-1:0] req_pad;
  logic [CMD_STREAM_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  accept_en;
  logic                  buf_ready;
  logic                  push;
  logic                  last_accept;

  // Widen the request vector so the shared search helper sees a fixed width.
  always_comb begin
    req_pad = '0;
    req_pad[NUM_SOURCES-1:0] = s_cmd_axis_tvalid;
  end

  assign pick = rr_pick(req_pad, last_grant_q, NUM_SOURCES);

  // Route the granted source's beat toward the skid buffer.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        sel_data  = s_cmd_axis_tdata[i*CMD_STREAM_WIDTH +: CMD_STREAM_WIDTH];
        sel_valid = s_cmd_axis_tvalid[i];
        sel_last  = s_cmd_axis_tlast[i];
      end
    end
  end

  assign accept_en   = (state_q == LOCKED) && !release_q;
  assign push        = accept_en && sel_valid && buf_ready;
  assign last_accept = push && sel_last;

  // Only the granted source sees ready, and only while the lock is live and
  // the buffer has room; every term here comes from a flop.
  always_comb begin
    s_cmd_axis_tready = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      s_cmd_axis_tready[i] = accept_en && buf_ready && (grant_q == GRANT_W'(i));
    end
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock on any request; unlock after the release cycle that follows tlast.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|s_cmd_axis_tvalid) state_d = LOCKED;
      LOCKED:  if (release_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping: capture the winner in IDLE, remember it as the last
  // grant once its packet ends, and flag the release cycle.
  always_ff @(posedge aclk) begin
    if (reset) begin
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(NUM_SOURCES - 1);
      release_q    <= 1'b0;
    end else begin
      if ((state_q == IDLE) && (|s_cmd_axis_tvalid)) begin
        grant_q <= pick;
      end
      if (last_accept) begin
        last_grant_q <= grant_q;
      end
      release_q <= last_accept;
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH(CMD_STREAM_WIDTH)
  ) u_skid (
    .aclk    (aclk),
    .reset   (reset),
    .s_valid (accept_en && sel_valid),
    .s_ready (buf_ready),
    .s_data  (sel_data),
    .s_last  (sel_last),
    .m_valid (m_cmd_axis_tvalid),
    .m_ready (m_cmd_axis_tready),
    .m_data  (m_cmd_axis_tdata),
    .m_last  (m_cmd_axis_tlast)
  );

  assign dbgGrant  = grant_q;
  assign dbgLocked = (state_q == LOCKED);

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Scoreboard bench for cmd_stream_arbiter: per-source drivers feed beat
// queues, expected output beats are queued as stimulus is loaded, and a
// monitor compares every merged-stream beat in order.
module tb_cmd_stream_arbiter;

  localparam int W = 16;
  localparam int N = 2;

  typedef logic [W:0] beat_t;

  logic            aclk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N-1:0]    s_tlast;
  logic [N*W-1:0]  s_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            m_tlast;
  logic [W-1:0]    m_tdata;
  logic [1:0]      dbgGrant;
  logic            dbgLocked;

  int     errors = 0;
  int     checks = 0;
  int     edge_cnt = 0;
  int     tot_acc = 0;
  int     tot_out = 0;
  logic   chk_lat = 1'b1;
  beat_t  sb[$];
  int     acc_edge[$];
  int     gap_edge[$];
  logic   gap_last[$];
  logic   rdy_q[$];

  always #5 aclk = ~aclk;

  always @(posedge aclk) edge_cnt <= edge_cnt + 1;

  cmd_stream_arbiter #(
    .CMD_STREAM_WIDTH(W),
    .NUM_SOURCES(N)
  ) dut (
    .aclk              (aclk),
    .reset             (reset),
    .s_cmd_axis_tvalid (s_tvalid),
    .s_cmd_axis_tready (s_tready),
    .s_cmd_axis_tlast  (s_tlast),
    .s_cmd_axis_tdata  (s_tdata),
    .m_cmd_axis_tvalid (m_tvalid),
    .m_cmd_axis_tready (m_tready),
    .m_cmd_axis_tlast  (m_tlast),
    .m_cmd_axis_tdata  (m_tdata),
    .dbgGrant          (dbgGrant),
    .dbgLocked         (dbgLocked)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // One driver per source: present the queue head at negedge (unless held by
  // limit), sample the handshake just before the edge, retire on the edge.
  for (genvar g = 0; g < N; g++) begin : src
    beat_t      q[$];
    int         limit = 1000000;
    int         acc_cnt = 0;
    logic       v = 1'b0;
    logic       l = 1'b0;
    logic [W-1:0] d = '0;

    assign s_tvalid[g]       = v;
    assign s_tlast[g]        = l;
    assign s_tdata[g*W +: W] = d;

    initial begin : drive
      beat_t b;
      logic  hs;
      int    ts;
      forever begin
        @(negedge aclk);
        if (q.size() > 0 && acc_cnt < limit) begin
          b = q[0];
          v = 1'b1;
          d = b[W-1:0];
          l = b[W];
        end else begin
          v = 1'b0;
          l = 1'b0;
        end
        #4;
        hs = v && s_tready[g] && !reset;
        ts = edge_cnt;
        @(posedge aclk);
        if (hs) begin
          void'(q.pop_front());
          acc_cnt++;
          tot_acc++;
          acc_edge.push_back(ts);
          gap_edge.push_back(ts);
          gap_last.push_back(l);
        end
      end
    end
  end

  // Output monitor: drives m ready from a pattern, checks stall stability,
  // ready back-pressure at full occupancy, beat order and latency.
  initial begin : monitor
    beat_t exp;
    beat_t got;
    beat_t prev;
    logic  hs;
    logic  stalled;
    int    a;
    stalled = 1'b0;
    prev    = '0;
    forever begin
      @(negedge aclk);
      m_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      #4;
      hs = 1'b0;
      if (!reset) begin
        got = {m_tlast, m_tdata};
        if (stalled) checkOutput("stall_hold", 32'({m_tvalid, got}), 32'({1'b1, prev}));
        if (tot_acc - tot_out == 2) checkOutput("full_ready", 32'(s_tready), 32'd0);
        if (m_tvalid && m_tready) begin
          hs = 1'b1;
          checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() > 0) begin
            exp = sb.pop_front();
            checkOutput("out_beat", 32'(got), 32'(exp));
          end
          if (acc_edge.size() > 0) begin
            a = acc_edge.pop_front();
            if (chk_lat) checkOutput("latency", 32'(edge_cnt - a), 32'd1);
          end
        end
        stalled = m_tvalid && !m_tready;
        prev    = got;
      end else begin
        stalled = 1'b0;
      end
      @(posedge aclk);
      if (hs) tot_out++;
    end
  end

  task automatic flushBench();
    src[0].q.delete();
    src[1].q.delete();
    src[0].acc_cnt = 0;
    src[1].acc_cnt = 0;
    src[0].limit = 1000000;
    src[1].limit = 1000000;
    sb.delete();
    acc_edge.delete();
    gap_edge.delete();
    gap_last.delete();
    rdy_q.delete();
    tot_acc = 0;
    tot_out = 0;
  endtask

  task automatic applyReset();
    @(negedge aclk);
    reset = 1'b1;
    #2;
    flushBench();
    repeat (2) @(negedge aclk);
    #1;
    checkOutput("rst_m_valid", 32'(m_tvalid), 32'd0);
    checkOutput("rst_m_last", 32'(m_tlast), 32'd0);
    checkOutput("rst_s_ready", 32'(s_tready), 32'd0);
    checkOutput("rst_locked", 32'(dbgLocked), 32'd0);
    checkOutput("rst_grant", 32'(dbgGrant), 32'd0);
    @(negedge aclk);
    reset = 1'b0;
    #2;
  endtask

  // Queue an n-beat packet on source s and its expected output beats.
  task automatic applyStimulus(input int s, input logic [W-1:0] first, input logic [W-1:0] step, input int n);
    beat_t        b;
    logic [W-1:0] data;
    for (int i = 0; i < n; i++) begin
      data = first + step * W'(i);
      b    = {(i == n - 1), data};
      if (s == 0) src[0].q.push_back(b);
      else        src[1].q.push_back(b);
      sb.push_back(b);
    end
  endtask

  task automatic waitDrain(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge aclk);
      if (sb.size() == 0 && src[0].q.size() == 0 && src[1].q.size() == 0) break;
    end
    #2;
    checkOutput("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin : main
    // Single 3-beat packet from source 0, one-cycle latency.
    applyReset();
    chk_lat = 1'b1;
    applyStimulus(0, 16'h0011, 16'h0011, 3);
    waitDrain(50);

    // Both sources continuously valid with 2-beat packets.
    applyReset();
    applyStimulus(0, 16'h0101, 16'h0001, 2);
    applyStimulus(1, 16'h0201, 16'h0001, 2);
    applyStimulus(0, 16'h0103, 16'h0001, 2);
    applyStimulus(1, 16'h0203, 16'h0001, 2);
    waitDrain(100);
    checkOutput("gap_count", 32'(gap_edge.size()), 32'd8);
    for (int i = 1; i < gap_edge.size(); i++) begin
      checkOutput("gap", 32'(gap_edge[i] - gap_edge[i-1]), gap_last[i-1] ? 32'd3 : 32'd1);
    end

    // Source 1 pauses mid-packet; source 0 must wait.
    applyReset();
    src[1].limit = 1;
    applyStimulus(1, 16'h1001, 16'h0001, 4);
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (src[1].acc_cnt >= 1) break;
    end
    checkOutput("src1_first_beat", 32'(src[1].acc_cnt), 32'd1);
    applyStimulus(0, 16'h0A01, 16'h0001, 2);
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      #1;
      checkOutput("src0_blocked", 32'(s_tready[0]), 32'd0);
    end
    checkOutput("hold_grant", 32'({dbgLocked, dbgGrant}), 32'({1'b1, 2'd1}));
    checkOutput("src1_paused", 32'(src[1].acc_cnt), 32'd1);
    checkOutput("src0_idle", 32'(src[0].acc_cnt), 32'd0);
    src[1].limit = 1000000;
    waitDrain(100);

    // Output back-pressure 1,0,0,1 during a 5-beat packet.
    applyReset();
    chk_lat = 1'b0;
    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b1);
    applyStimulus(0, 16'h5001, 16'h0001, 5);
    waitDrain(60);
    chk_lat = 1'b1;

    // Reset during beat 2 of a 4-beat packet.
    applyReset();
    applyStimulus(0, 16'h3001, 16'h0001, 4);
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (src[0].acc_cnt >= 1) break;
    end
    checkOutput("mid_first_beat", 32'(src[0].acc_cnt), 32'd1);
    reset = 1'b1;
    #2;
    flushBench();
    @(negedge aclk);
    #1;
    checkOutput("mid_rst_m_valid", 32'(m_tvalid), 32'd0);
    checkOutput("mid_rst_s_ready", 32'(s_tready), 32'd0);
    checkOutput("mid_rst_locked", 32'(dbgLocked), 32'd0);
    reset = 1'b0;
    #1;
    applyStimulus(0, 16'h4001, 16'h0001, 2);
    applyStimulus(1, 16'h4101, 16'h0001, 2);
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      #1;
      if (dbgLocked) break;
    end
    checkOutput("post_rst_locked", 32'(dbgLocked), 32'd1);
    checkOutput("post_rst_grant", 32'(dbgGrant), 32'd0);
    waitDrain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
